pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 151 +++++++++++++++
 tb/tb_pc_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program counter generator for a single-issue fetch front end.
//
// The block normally walks the fetch address forward by 4. When the EX stage
// resolves a taken control transfer, the block raises Redirect so that IF/ID
// can be flushed, and the fetch address is moved to the resolved target. If
// instruction memory is not accepting the request, the target is parked in a
// pending register and applied as soon as Fetch_ready returns.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   When defined, a target with bit1 set is replaced by TRAP_VEC. Misalign
//   then pulses in the same cycle as Redirect.
//   When undefined, Misalign is tied 0 and targets are used unmodified.
//
// Parameters:
//   XLEN      address/data width
//   RESET_VEC Pc value at reset
//   TRAP_VEC  redirect target for a misaligned control transfer
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   Fetch_ready  in   instruction memory accepts Pc this cycle
//   Stall        in   hazard hold of sequential advance (not of redirects)
//   Branch/Zero  in   conditional branch, taken when both are 1
//   Jal          in   PC-relative jump
//   Jalr         in   register-indirect jump
//   Ex_pc        in   PC of the EX-stage instruction
//   Imm_In       in   immediate (halfword units for Branch/Jal, bytes for Jalr)
//   Rs_data1     in   Jalr base register
//   Pc           out  current fetch address (registered)
//   Pc_valid     out  Pc is a valid fetch request (registered)
//   Pc_plus4     out  link value Ex_pc + 4 (combinational)
//   Redirect     out  flush IF/ID (combinational)
//   Misalign     out  misaligned-target trap pulse (combinational)
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Fetch_ready,
  input  logic            Stall,
  input  logic            Branch,
  input  logic            Zero,
  input  logic            Jal,
  input  logic            Jalr,
  input  logic [XLEN-1:0] Ex_pc,
  input  logic [XLEN-1:0] Imm_In,
  input  logic [XLEN-1:0] Rs_data1,
  output logic [XLEN-1:0] Pc,
  output logic            Pc_valid,
  output logic [XLEN-1:0] Pc_plus4,
  output logic            Redirect,
  output logic            Misalign
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,  // one cycle after reset, no fetch issued
    S_RUN  = 2'd1,  // normal fetch
    S_PEND = 2'd2   // redirect target parked until memory accepts
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend;
  logic            r_valid;

  logic            w_taken;
  logic            w_active;
  logic            w_redirect;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_rel_tgt;
  logic [XLEN-1:0] w_raw_tgt;
  logic [XLEN-1:0] w_tgt;
  logic            w_mis_tgt;

  // Target selection: Jalr wins over Jal, Jal over Branch. Jal and Branch
  // share the PC-relative adder, so only Jalr needs its own path.
  always_comb begin
    w_taken    = Jalr | Jal | (Branch & Zero);
    w_jalr_sum = Rs_data1 + Imm_In;
    w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
    w_rel_tgt  = Ex_pc + {Imm_In[XLEN-2:0], 1'b0};
    w_raw_tgt  = Jalr ? w_jalr_tgt : w_rel_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    // Bit0 is always 0 here, so bit1 alone decides 4-byte misalignment.
    w_mis_tgt  = w_raw_tgt[1];
    w_tgt      = w_mis_tgt ? TRAP_VEC : w_raw_tgt;
`else
    w_mis_tgt  = 1'b0;
    w_tgt      = w_raw_tgt;
`endif
  end

  // Control transfers seen during BOOT refer to nothing fetched yet.
  assign w_active   = (r_state != S_BOOT);
  assign w_redirect = w_taken & w_active;

  assign Redirect = w_redirect;
  assign Misalign = w_redirect & w_mis_tgt;
  assign Pc_plus4 = Ex_pc + XLEN'(4);
  assign Pc       = r_pc;
  assign Pc_valid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VEC;
      r_pend  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
        end
        S_RUN: begin
          // Redirect is checked first so that Stall never blocks it.
          if (w_taken) begin
            if (Fetch_ready) begin
              r_pc <= w_tgt;
            end else begin
              r_pend  <= w_tgt;
              r_state <= S_PEND;
            end
          end else if (Fetch_ready && !Stall) begin
            r_pc <= r_pc + XLEN'(4);
          end
        end
        S_PEND: begin
          // Pc stays put while memory holds off; a newer redirect replaces
          // the parked one, and one arriving with Fetch_ready is used directly.
          if (w_taken) r_pend <= w_tgt;
          if (Fetch_ready) begin
            r_pc    <= w_taken ? w_tgt : r_pend;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_BOOT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- directed bench for pc_gen. A behavioural model tracks the
// expected fetch address, and the bench compares every output against it once
// per cycle. Literal expectations pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_pc_gen;
  localparam int XLEN = 32;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            Fetch_ready = 1'b1, Stall = 1'b0;
  logic            Branch = 1'b0, Zero = 1'b0, Jal = 1'b0, Jalr = 1'b0;
  logic [XLEN-1:0] Ex_pc = '0, Imm_In = '0, Rs_data1 = '0;
  logic [XLEN-1:0] Pc, Pc_plus4;
  logic            Pc_valid, Redirect, Misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .Fetch_ready(Fetch_ready), .Stall(Stall),
    .Branch(Branch), .Zero(Zero), .Jal(Jal), .Jalr(Jalr), .Ex_pc(Ex_pc),
    .Imm_In(Imm_In), .Rs_data1(Rs_data1), .Pc(Pc), .Pc_valid(Pc_valid),
    .Pc_plus4(Pc_plus4), .Redirect(Redirect), .Misalign(Misalign)
  );

  // ---------------- model ----------------
  logic            m_booted, m_pend;
  logic [XLEN-1:0] m_ptgt, m_pc;

  function automatic logic m_taken();
    return Jalr | Jal | (Branch & Zero);
  endfunction

  function automatic logic [XLEN-1:0] m_raw();
    if (Jalr) return (Rs_data1 + Imm_In) & ~32'h1;
    return Ex_pc + Imm_In * 2;
  endfunction

  function automatic logic m_bad();
    return MIS && (m_raw() % 4 != 0);
  endfunction

  function automatic logic [XLEN-1:0] m_tgt();
    return m_bad() ? 32'h100 : m_raw();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_booted <= 1'b0; m_pend <= 1'b0; m_ptgt <= '0; m_pc <= '0;
    end else if (!m_booted) begin
      m_booted <= 1'b1;
    end else if (m_pend) begin
      if (m_taken()) m_ptgt <= m_tgt();
      if (Fetch_ready) begin
        m_pc   <= m_taken() ? m_tgt() : m_ptgt;
        m_pend <= 1'b0;
      end
    end else if (m_taken()) begin
      if (Fetch_ready) m_pc <= m_tgt();
      else begin m_ptgt <= m_tgt(); m_pend <= 1'b1; end
    end else if (Fetch_ready && !Stall) begin
      m_pc <= m_pc + 4;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic redir;
    redir = m_booted & m_taken();
    chk("m_pc", Pc, m_pc);
    chk("m_valid", {31'b0, Pc_valid}, {31'b0, m_booted});
    chk("m_redirect", {31'b0, Redirect}, {31'b0, redir});
    chk("m_misalign", {31'b0, Misalign}, {31'b0, redir & m_bad()});
    chk("m_plus4", Pc_plus4, Ex_pc + 4);
  endtask

  task automatic set(input logic br, input logic zr, input logic jl, input logic jr,
                     input logic fr, input logic st, input logic [XLEN-1:0] ex,
                     input logic [XLEN-1:0] im, input logic [XLEN-1:0] rs);
    Branch = br; Zero = zr; Jal = jl; Jalr = jr; Fetch_ready = fr; Stall = st;
    Ex_pc = ex; Imm_In = im; Rs_data1 = rs;
    #2;
    cmp_model();
  endtask

  task automatic idle(input logic fr, input logic st);
    set(0, 0, 0, 0, fr, st, 0, 0, 0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // in reset: taken inputs have no effect
    set(0, 0, 1, 0, 1, 0, 32'h40, 32'h10, 0);
    chk("rst_pc", Pc, 0); chk("rst_valid", {31'b0, Pc_valid}, 0);
    chk("rst_redirect", {31'b0, Redirect}, 0);
    nxt();
    // release: BOOT cycle then sequential fetch
    rst_n = 1'b1;
    idle(1, 0); chk("boot_pc", Pc, 0); chk("boot_valid", {31'b0, Pc_valid}, 0); nxt();
    idle(1, 0); chk("seq0", Pc, 0); chk("seq_valid", {31'b0, Pc_valid}, 1); nxt();
    idle(1, 0); chk("seq4", Pc, 4); nxt();
    idle(1, 0); chk("seq8", Pc, 8); nxt();
    idle(1, 0); chk("seq12", Pc, 12); nxt();
    // branch taken / not taken
    set(1, 1, 0, 0, 1, 0, 32'h40, 32'h10, 0);
    chk("br_redirect", {31'b0, Redirect}, 1); nxt();
    set(1, 0, 0, 0, 1, 0, 32'h40, 32'h10, 0);
    chk("br_pc", Pc, 32'h60); chk("br_nt_redirect", {31'b0, Redirect}, 0); nxt();
    idle(1, 0); chk("br_nt_pc", Pc, 32'h64); nxt();
    // jalr with bit0 cleared, bit1 set
    set(0, 0, 0, 1, 1, 0, 0, 32'h4, 32'h1003);
    chk("jalr_redirect", {31'b0, Redirect}, 1);
    chk("jalr_misalign", {31'b0, Misalign}, {31'b0, MIS}); nxt();
    idle(1, 0); chk("jalr_pc", Pc, MIS ? 32'h100 : 32'h1006); nxt();
    // reach Pc=8, then redirect while memory busy
    set(0, 0, 1, 0, 1, 0, 0, 32'h4, 0); nxt();
    set(0, 0, 1, 0, 0, 0, 0, 32'h20, 0);
    chk("pend_pc0", Pc, 8); chk("pend_redirect", {31'b0, Redirect}, 1); nxt();
    idle(0, 0); chk("pend_hold", Pc, 8); chk("pend_valid", {31'b0, Pc_valid}, 1); nxt();
    idle(1, 0); chk("pend_hold2", Pc, 8); nxt();
    idle(1, 0); chk("pend_apply", Pc, 32'h40); nxt();
    // last redirect wins while pending
    set(0, 0, 1, 0, 0, 0, 0, 32'h80, 0); nxt();
    set(1, 1, 0, 0, 0, 0, 32'h200, 32'h8, 0); nxt();
    idle(1, 0); chk("lw_hold", Pc, 32'h44); nxt();
    // new redirect in the same cycle memory accepts
    set(0, 0, 1, 0, 0, 0, 0, 32'h100, 0); chk("lw_apply", Pc, 32'h210); nxt();
    set(0, 0, 1, 0, 1, 0, 32'h1000, 32'h8, 0); chk("same_hold", Pc, 32'h210); nxt();
    // stall holds sequential advance
    idle(1, 1); chk("same_apply", Pc, 32'h1010); nxt();
    idle(1, 1); chk("stall1", Pc, 32'h1010); nxt();
    idle(1, 1); chk("stall2", Pc, 32'h1010); nxt();
    set(0, 0, 1, 0, 1, 1, 32'h80, 32'h8, 0);
    chk("stall3", Pc, 32'h1010); chk("stall_redirect", {31'b0, Redirect}, 1); nxt();
    idle(0, 0); chk("stall_jal_pc", Pc, 32'h90); nxt();
    idle(0, 0); chk("busy_hold", Pc, 32'h90); nxt();
    // modular arithmetic and negative offsets
    set(0, 0, 0, 1, 1, 0, 0, 32'h8, 32'hFFFF_FFFC); nxt();
    set(0, 0, 1, 0, 1, 0, 32'h100, 32'hFFFF_FFF8, 0); chk("wrap_jalr", Pc, 4); nxt();
    set(0, 0, 1, 0, 1, 0, 0, 32'h1, 0);
    chk("neg_jal", Pc, 32'hF0); chk("jal_misalign", {31'b0, Misalign}, {31'b0, MIS}); nxt();
    idle(1, 0); chk("jal_mis_pc", Pc, MIS ? 32'h100 : 32'h2); nxt();
    // reset while pending
    set(0, 0, 1, 0, 0, 0, 0, 32'h40, 0); nxt();
    idle(0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", Pc, 0); chk("async_valid", {31'b0, Pc_valid}, 0);
    cmp_model();
    nxt();
    rst_n = 1'b1;
    set(0, 0, 1, 0, 1, 0, 0, 32'h40, 0);
    chk("boot_ignore", {31'b0, Redirect}, 0); chk("boot2_pc", Pc, 0); nxt();
    idle(1, 0); chk("nopend0", Pc, 0); nxt();
    idle(1, 0); chk("nopend4", Pc, 4); nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
